// File: rtl/cache_control.sv
// Sequencer between the CPU port, a 4-way write-back cache array and next-level memory.
// Runs one request at a time: lookup, victim write-back, refill, install and retry.
module cache_control #(
    parameter int ADDR_W  = 30,
    parameter int INDEX_W = 10,
    parameter int TAG_W   = 20,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic              cpu_ready_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic [ADDR_W-1:0] c_addr_o,
    output logic              c_rd_o,
    output logic              c_wr_o,
    output logic [DATA_W-1:0] c_wdata_o,
    output logic              c_substitude_o,
    output logic [DATA_W-1:0] c_sub_data_o,
    input  logic [DATA_W-1:0] c_data_i,
    input  logic              c_r_hit_i,
    input  logic              c_r_miss_i,
    input  logic              c_w_hit_i,
    input  logic              c_w_miss_i,
    input  logic              c_dirty_i,
    input  logic [DATA_W-1:0] c_wb_data_i,
    input  logic [TAG_W-1:0]  c_victim_tag_i,
    input  logic              c_sub_fin_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WCHK, S_VICTIM, S_WB, S_REFILL, S_FILL, S_FWAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q;
    logic                wr_q;
    logic                missed_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                cpu_ready_q, c_rd_q, c_wr_q, c_sub_q, mem_req_q, mem_we_q;
    logic [DATA_W-1:0]   cpu_rdata_q, c_wdata_q, c_sub_data_q, mem_wdata_q;
    logic [ADDR_W-1:0]   c_addr_q, mem_addr_q;
    logic [CNT_W-1:0]    hit_q, miss_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_q         <= 1'b0;
            missed_q     <= 1'b0;
            wdata_q      <= '0;
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            c_addr_q     <= '0;
            c_rd_q       <= 1'b0;
            c_wr_q       <= 1'b0;
            c_wdata_q    <= '0;
            c_sub_q      <= 1'b0;
            c_sub_data_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            // Strobes and the completion pulse are single-cycle unless re-armed below.
            cpu_ready_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            c_rd_q       <= 1'b0;
            c_wr_q       <= 1'b0;
            c_wdata_q    <= '0;
            c_sub_q      <= 1'b0;
            c_sub_data_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_rd_i || cpu_wr_i) begin
                        wr_q     <= cpu_wr_i;
                        wdata_q  <= cpu_wdata_i;
                        missed_q <= 1'b0;
                        c_addr_q <= cpu_addr_i;
                        if (cpu_wr_i) begin
                            c_wr_q    <= 1'b1;
                            c_wdata_q <= cpu_wdata_i;
                        end else begin
                            c_rd_q <= 1'b1;
                        end
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (wr_q) begin
                        state_q <= S_WCHK;
                    end else if (c_r_hit_i) begin
                        cpu_ready_q <= 1'b1;
                        cpu_rdata_q <= c_data_i;
                        if (!missed_q && hit_q != '1) hit_q <= hit_q + CNT_ONE;
                        c_addr_q <= '0;
                        state_q  <= S_IDLE;
                    end else if (c_r_miss_i) begin
                        state_q <= S_VICTIM;
                    end else begin
                        c_rd_q <= 1'b1;
                    end
                end
                S_WCHK: begin
                    if (c_w_hit_i) begin
                        cpu_ready_q <= 1'b1;
                        if (!missed_q && hit_q != '1) hit_q <= hit_q + CNT_ONE;
                        c_addr_q <= '0;
                        state_q  <= S_IDLE;
                    end else if (c_w_miss_i) begin
                        state_q <= S_VICTIM;
                    end
                end
                S_VICTIM: begin
                    // A retried access that misses again is still one miss.
                    if (!missed_q && miss_q != '1) miss_q <= miss_q + CNT_ONE;
                    missed_q  <= 1'b1;
                    mem_req_q <= 1'b1;
                    if (c_dirty_i) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {c_victim_tag_i, c_addr_q[INDEX_W-1:0]};
                        mem_wdata_q <= c_wb_data_i;
                        state_q     <= S_WB;
                    end else begin
                        mem_addr_q <= c_addr_q;
                        state_q    <= S_REFILL;
                    end
                end
                S_WB: begin
                    if (mem_ack_i) begin
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        mem_addr_q  <= c_addr_q;
                        state_q     <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (mem_ack_i) begin
                        mem_req_q    <= 1'b0;
                        mem_addr_q   <= '0;
                        c_sub_q      <= 1'b1;
                        c_sub_data_q <= mem_rdata_i;
                        state_q      <= S_FILL;
                    end
                end
                S_FILL: begin
                    state_q <= S_FWAIT;
                end
                S_FWAIT: begin
                    if (c_sub_fin_i) begin
                        if (wr_q) begin
                            c_wr_q    <= 1'b1;
                            c_wdata_q <= wdata_q;
                        end else begin
                            c_rd_q <= 1'b1;
                        end
                        state_q <= S_LOOKUP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_ready_o    = cpu_ready_q;
    assign cpu_rdata_o    = cpu_rdata_q;
    assign c_addr_o       = c_addr_q;
    assign c_rd_o         = c_rd_q;
    assign c_wr_o         = c_wr_q;
    assign c_wdata_o      = c_wdata_q;
    assign c_substitude_o = c_sub_q;
    assign c_sub_data_o   = c_sub_data_q;
    assign mem_req_o      = mem_req_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign hit_cnt_o      = hit_q;
    assign miss_cnt_o     = miss_q;

endmodule
